// File: rtl/spi_fnd_frame_ctrl.sv
// Frame sequencer for the FND link: sends a 16-bit value as one chip-select frame,
// low byte then high byte, through a byte-level SPI master start/ready/done handshake.
module spi_fnd_frame_ctrl #(
  parameter int CS_SETUP    = 2,
  parameter int BYTE_GAP    = 1,
  parameter int CS_HOLD     = 2,
  parameter int AUTO_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic        auto_en,
  input  logic [15:0] data_in,
  input  logic        m_ready,
  input  logic        m_done,
  output logic        m_start,
  output logic [7:0]  m_tx_data,
  output logic        cs_n,
  output logic        busy,
  output logic        frame_done,
  output logic        pending
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETUP   = 4'd1;
  localparam logic [3:0] S_L_START = 4'd2;
  localparam logic [3:0] S_L_WAIT  = 4'd3;
  localparam logic [3:0] S_GAP     = 4'd4;
  localparam logic [3:0] S_H_START = 4'd5;
  localparam logic [3:0] S_H_WAIT  = 4'd6;
  localparam logic [3:0] S_HOLD    = 4'd7;
  localparam logic [3:0] S_FIN     = 4'd8;

  logic [3:0]  r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_shadow;
  logic [31:0] r_auto_cnt;

  logic [3:0]  w_next;
  logic [7:0]  w_cnt_next;
  logic        w_auto_tick;
  logic        w_req;
  logic        w_launch;

  assign w_auto_tick = auto_en && (r_auto_cnt == 32'(AUTO_PERIOD - 1));
  assign w_req       = send | w_auto_tick;
  assign w_launch    = (r_state == S_IDLE) && (w_req || pending);

  // m_start is a registered decision taken one cycle ahead, so the START
  // states leave as soon as the pulse they issued is on the wire.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_next     = S_SETUP;
          w_cnt_next = 8'd0;
        end
      end
      S_SETUP: begin
        if (r_cnt == 8'(CS_SETUP - 1)) w_next = S_L_START;
        else                           w_cnt_next = r_cnt + 8'd1;
      end
      S_L_START: if (m_start) w_next = S_L_WAIT;
      S_L_WAIT: begin
        if (m_done) begin
          if (BYTE_GAP == 0) begin
            w_next = S_H_START;
          end else begin
            w_next     = S_GAP;
            w_cnt_next = 8'd0;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == 8'(BYTE_GAP - 1)) w_next = S_H_START;
        else                           w_cnt_next = r_cnt + 8'd1;
      end
      S_H_START: if (m_start) w_next = S_H_WAIT;
      S_H_WAIT: begin
        if (m_done) begin
          w_next     = S_HOLD;
          w_cnt_next = 8'd0;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'(CS_HOLD - 1)) w_next = S_FIN;
        else                          w_cnt_next = r_cnt + 8'd1;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_shadow   <= 16'd0;
      r_auto_cnt <= 32'd0;
      pending    <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      m_start    <= 1'b0;
      m_tx_data  <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_launch) r_shadow <= data_in;

      if (!auto_en || w_auto_tick) r_auto_cnt <= 32'd0;
      else                         r_auto_cnt <= r_auto_cnt + 32'd1;

      if (w_launch)   pending <= 1'b0;
      else if (w_req) pending <= 1'b1;

      // Outputs follow the state being entered so they line up with it.
      cs_n       <= (w_next == S_IDLE) || (w_next == S_FIN);
      busy       <= (w_next != S_IDLE);
      frame_done <= (w_next == S_FIN);
      m_start    <= ((w_next == S_L_START) || (w_next == S_H_START)) && m_ready;
      if (w_next == S_L_START)      m_tx_data <= r_shadow[7:0];
      else if (w_next == S_H_START) m_tx_data <= r_shadow[15:8];
    end
  end

endmodule

// File: tb/tb_spi_fnd_frame_ctrl.sv
// Bench for spi_fnd_frame_ctrl: byte-master models, a frame scoreboard that watches
// every cycle, and directed frame-timing vectors for two parameter sets.
module tb_spi_fnd_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        send, auto_en, send2, auto2;
  logic [15:0] data_in, data2;

  logic [1:0] ms, mr, rdy_en;
  logic [1:0] md    = 2'b00;
  logic [1:0] mbusy = 2'b00;
  int         mcnt[2];
  int         blen[2];

  logic [7:0] tx0, tx1;
  logic       cs0, cs1, busy0, busy1, fd0, fd1, pend0, pend1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_fnd_frame_ctrl #(.CS_SETUP(2), .BYTE_GAP(1), .CS_HOLD(2), .AUTO_PERIOD(50)) dut (
    .clk(clk), .rst(rst), .send(send), .auto_en(auto_en), .data_in(data_in),
    .m_ready(mr[0]), .m_done(md[0]), .m_start(ms[0]), .m_tx_data(tx0),
    .cs_n(cs0), .busy(busy0), .frame_done(fd0), .pending(pend0)
  );

  spi_fnd_frame_ctrl #(.CS_SETUP(1), .BYTE_GAP(0), .CS_HOLD(2), .AUTO_PERIOD(100000)) dut2 (
    .clk(clk), .rst(rst), .send(send2), .auto_en(auto2), .data_in(data2),
    .m_ready(mr[1]), .m_done(md[1]), .m_start(ms[1]), .m_tx_data(tx1),
    .cs_n(cs1), .busy(busy1), .frame_done(fd1), .pending(pend1)
  );

  // Byte master: done arrives blen cycles after start; ready while not shifting.
  assign mr = rdy_en & ~mbusy;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      md[k] <= 1'b0;
      if (mbusy[k]) begin
        if (mcnt[k] == 0) begin
          mbusy[k] <= 1'b0;
          md[k]    <= 1'b1;
        end else begin
          mcnt[k] <= mcnt[k] - 1;
        end
      end else if (ms[k]) begin
        if (blen[k] == 1) md[k] <= 1'b1;
        else begin
          mbusy[k] <= 1'b1;
          mcnt[k]  <= blen[k] - 2;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int at(int q[$], int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Scoreboard: expected frames in launch order, two bytes each, low byte first.
  logic [15:0] exp_q[$];
  int          phase = 0;
  logic        in_flight = 1'b0;
  logic [7:0]  held = 8'd0;
  int start_log[$], tx_log[$], fd_log[$];
  int cs_low = 0;
  int start2_log[$], tx2_log[$], fd2_log[$];
  int cs2_low = 0;

  always @(negedge clk) begin
    if (rst) begin
      phase     = 0;
      in_flight = 1'b0;
      exp_q.delete();
    end else begin
      if (!busy0) check("idle_cs_high", int'(cs0), 1);
      if (in_flight) begin
        check("tx_stable", int'(tx0), int'(held));
        if (md[0]) in_flight = 1'b0;
      end
      if (!cs0) cs_low++;
      if (ms[0]) begin
        start_log.push_back(cyc);
        tx_log.push_back(int'(tx0));
        check("start_cs_low", int'(cs0), 0);
        check("start_expected", int'(exp_q.size() > 0 && phase < 2), 1);
        if (exp_q.size() > 0 && phase < 2)
          check("tx_byte", int'(tx0), int'(phase == 0 ? exp_q[0][7:0] : exp_q[0][15:8]));
        in_flight = 1'b1;
        held      = tx0;
        phase++;
      end
      if (fd0) begin
        fd_log.push_back(cyc);
        check("fd_cs_high", int'(cs0), 1);
        check("fd_two_bytes", phase, 2);
        check("fd_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!cs1) cs2_low++;
      if (ms[1]) begin
        start2_log.push_back(cyc);
        tx2_log.push_back(int'(tx1));
      end
      if (fd1) fd2_log.push_back(cyc);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    start_log.delete(); tx_log.delete(); fd_log.delete(); cs_low = 0;
    start2_log.delete(); tx2_log.delete(); fd2_log.delete(); cs2_low = 0;
  endtask

  task automatic do_send(logic [15:0] d);
    data_in = d;
    send    = 1'b1;
    tick(1);
    send    = 1'b0;
  endtask

  int t0;

  initial begin
    rst = 1'b1; send = 1'b0; auto_en = 1'b0; data_in = 16'h0;
    send2 = 1'b0; auto2 = 1'b0; data2 = 16'h0;
    rdy_en = 2'b11; blen[0] = 1; blen[1] = 1;
    tick(3);
    check("rst_cs_n", int'(cs0), 1);
    check("rst_m_start", int'(ms[0]), 0);
    check("rst_tx", int'(tx0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_frame_done", int'(fd0), 0);
    check("rst_pending", int'(pend0), 0);
    rst = 1'b0;
    tick(3);

    // Minimum frame, 1-cycle bytes
    clear_logs(); exp_q.push_back(16'h0F3C);
    t0 = cyc; do_send(16'h0F3C); goto(t0 + 20);
    check("min_starts", start_log.size(), 2);
    check("min_start0", at(start_log, 0) - t0, 3);
    check("min_start1", at(start_log, 1) - t0, 6);
    check("min_fd_count", fd_log.size(), 1);
    check("min_fd", at(fd_log, 0) - t0, 10);
    check("min_cs_low", cs_low, 9);
    check("min_tx0", at(tx_log, 0), 'h3C);
    check("min_tx1", at(tx_log, 1), 'h0F);

    // A55A with 8-cycle bytes
    blen[0] = 8;
    clear_logs(); exp_q.push_back(16'hA55A);
    t0 = cyc; do_send(16'hA55A); goto(t0 + 40);
    check("a55a_starts", start_log.size(), 2);
    check("a55a_start1", at(start_log, 1) - t0, 13);
    check("a55a_fd", at(fd_log, 0) - t0, 24);
    check("a55a_fd_count", fd_log.size(), 1);
    check("a55a_tx0", at(tx_log, 0), 'h5A);
    check("a55a_tx1", at(tx_log, 1), 'hA5);
    check("a55a_cs_low", cs_low, 23);
    check("a55a_cs_after", int'(cs0), 1);

    // Master not ready for 20 cycles in L_START
    blen[0] = 1; rdy_en[0] = 1'b0;
    clear_logs(); exp_q.push_back(16'h7E81);
    t0 = cyc; do_send(16'h7E81); goto(t0 + 23);
    check("stall_no_start", int'(ms[0]), 0);
    check("stall_cs_low", int'(cs0), 0);
    rdy_en[0] = 1'b1;
    goto(t0 + 40);
    check("stall_starts", start_log.size(), 2);
    check("stall_start0", at(start_log, 0) - t0, 24);
    check("stall_start1", at(start_log, 1) - t0, 27);
    check("stall_fd", at(fd_log, 0) - t0, 31);

    // Requests during a frame queue one deep; the next frame samples at launch
    blen[0] = 8;
    clear_logs(); exp_q.push_back(16'h1A1B); exp_q.push_back(16'h3A3B);
    t0 = cyc; do_send(16'h1A1B);
    goto(t0 + 5);  do_send(16'h2A2B);
    check("pend_set", int'(pend0), 1);
    goto(t0 + 10); do_send(16'h3A3B);
    goto(t0 + 15); do_send(16'h3A3B);
    goto(t0 + 25);
    check("pend_in_idle", int'(pend0), 1);
    tick(1);
    check("pend_cleared", int'(pend0), 0);
    goto(t0 + 80);
    check("pend_fd_count", fd_log.size(), 2);
    check("pend_fd0", at(fd_log, 0) - t0, 24);
    check("pend_fd1", at(fd_log, 1) - t0, 49);
    check("pend_start2", at(start_log, 2) - t0, 28);
    check("pend_tx2", at(tx_log, 2), 'h3B);
    check("pend_tx3", at(tx_log, 3), 'h3A);

    // Auto refresh every 50 cycles; send on a tick is one request
    blen[0] = 1;
    clear_logs(); data_in = 16'hBEEF;
    repeat (3) exp_q.push_back(16'hBEEF);
    t0 = cyc; auto_en = 1'b1;
    goto(t0 + 149); send = 1'b1; tick(1); send = 1'b0;
    goto(t0 + 151);
    check("auto_no_pend", int'(pend0), 0);
    goto(t0 + 155); auto_en = 1'b0;
    goto(t0 + 260);
    check("auto_starts", start_log.size(), 6);
    check("auto_start0", at(start_log, 0) - t0, 52);
    check("auto_start2", at(start_log, 2) - t0, 102);
    check("auto_start4", at(start_log, 4) - t0, 152);
    check("auto_fd_count", fd_log.size(), 3);
    check("auto_fd2", at(fd_log, 2) - t0, 159);

    // Reset in H_WAIT, then a clean frame
    blen[0] = 8;
    clear_logs(); exp_q.push_back(16'hA55A);
    t0 = cyc; do_send(16'hA55A); goto(t0 + 16);
    check("hw_busy", int'(busy0), 1);
    check("hw_cs_low", int'(cs0), 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_cs", int'(cs0), 1);
    check("rst_async_start", int'(ms[0]), 0);
    check("rst_async_busy", int'(busy0), 0);
    tick(2); rst = 1'b0;
    goto(t0 + 50);
    check("rst_no_fd", fd_log.size(), 0);
    clear_logs(); exp_q.push_back(16'h1234);
    t0 = cyc; do_send(16'h1234); goto(t0 + 40);
    check("post_rst_fd", at(fd_log, 0) - t0, 24);
    check("post_rst_starts", start_log.size(), 2);
    check("post_rst_tx0", at(tx_log, 0), 'h34);
    check("post_rst_tx1", at(tx_log, 1), 'h12);

    // CS_SETUP=1, BYTE_GAP=0 instance
    clear_logs();
    t0 = cyc; data2 = 16'hC33C; send2 = 1'b1; tick(1); send2 = 1'b0;
    goto(t0 + 20);
    check("sw_starts", start2_log.size(), 2);
    check("sw_start0", at(start2_log, 0) - t0, 2);
    check("sw_start1", at(start2_log, 1) - t0, 4);
    check("sw_fd_count", fd2_log.size(), 1);
    check("sw_fd", at(fd2_log, 0) - t0, 8);
    check("sw_cs_low", cs2_low, 7);
    check("sw_tx0", at(tx2_log, 0), 'h3C);
    check("sw_tx1", at(tx2_log, 1), 'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_fnd_frame_ctrl.md
Name: spi_fnd_frame_ctrl

Overview:
Master-side frame sequencer that sends a 16-bit FND value to the SPI slave as one chip-select frame: the low byte first, then the high byte. It drives an existing byte-level SPI master through a start/ready/done handshake and owns the chip-select line. It supports single-shot sends and periodic automatic refresh, so the slave's two-byte display assembler always receives complete, correctly ordered frames.

Parameters:
CS_SETUP, 2, cycles cs_n is low before the first byte start (legal range 1..255)
BYTE_GAP, 1, idle cycles between the low-byte done and the high-byte start (0..255; 0 means no gap state)
CS_HOLD, 2, cycles cs_n stays low after the high-byte done (1..255)
AUTO_PERIOD, 100000, cycles between automatic frame requests when auto_en=1 (must be at least 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
send  in  1  one-cycle request to transmit data_in
auto_en  in  1  enables periodic auto-send of data_in
data_in  in  16  value to transmit; [7:0] is the low byte
m_ready  in  1  SPI master idle and able to accept start
m_done  in  1  one-cycle pulse when the SPI master finishes a byte
m_start  out  1  one-cycle start pulse to the SPI master
m_tx_data  out  8  byte presented to the SPI master; held stable from m_start until m_done
cs_n  out  1  slave chip select, active-low
busy  out  1  high while a frame is in progress (any state other than IDLE)
frame_done  out  1  one-cycle pulse after the frame completes and cs_n returns high
pending  out  1  a request is queued behind the current frame

Behaviour:
- Reset (asynchronous) values: cs_n=1, m_start=0, m_tx_data=0, busy=0, frame_done=0, pending=0, state=IDLE, shadow=0, auto counter=0.
- All outputs are registered.
- Request source: req = send OR auto_tick.
  - auto_tick is a one-cycle pulse when the auto counter reaches AUTO_PERIOD-1.
  - The counter runs only while auto_en=1. It clears to 0 when auto_en=0 and on each tick.
  - send and auto_tick in the same cycle count as one request.
- States: IDLE, SETUP, L_START, L_WAIT, GAP, H_START, H_WAIT, HOLD, FIN.
- IDLE: on req or pending, latch data_in into the 16-bit shadow, clear pending, and go to SETUP. cs_n falls in the first SETUP cycle.
- SETUP: lasts exactly CS_SETUP cycles, then go to L_START.
- L_START: m_tx_data = shadow[7:0]. When m_ready=1, pulse m_start for one cycle and go to L_WAIT. If m_ready=0, wait in L_START.
- L_WAIT: on m_done, go to GAP, or straight to H_START if BYTE_GAP=0.
- GAP: lasts BYTE_GAP cycles, then go to H_START.
- H_START / H_WAIT: same as the low-byte states, using shadow[15:8]. On m_done go to HOLD.
- HOLD: cs_n stays low for CS_HOLD cycles, then go to FIN.
- FIN: cs_n=1 and frame_done=1 for one cycle, then go to IDLE. This guarantees at least 2 cycles of cs_n high between frames (FIN plus IDLE).
- Requests while busy: set pending=1 (one deep). Further requests while pending do not stack.
  - The shadow is NOT updated mid-frame. The next frame samples data_in when it launches from IDLE.
- m_done outside L_WAIT/H_WAIT: ignored.
- m_start is never asserted while cs_n=1.
- Reset mid-frame: cs_n goes high immediately (asynchronously), m_start drops, and the partial frame is discarded with no frame_done.
- auto_en falling mid-frame: the current frame completes normally. An already-set pending is still served.
- Minimum frame length with m_ready=1 and a 1-cycle SPI byte is deterministic. For the defaults (CS_SETUP=2, BYTE_GAP=1, CS_HOLD=2) the sequence is:
  - send at cycle 0
  - cs_n low in cycles 1–2 (SETUP)
  - m_start at cycle 3
  - done at cycle 4
  - GAP at cycle 5
  - m_start at cycle 6
  - done at cycle 7
  - HOLD at cycles 8–9
  - FIN with frame_done at cycle 10

Test Plan:
- Single send, data_in=16'hA55A, master model ready with 8-cycle bytes -> cs_n low for the whole frame; m_tx_data=8'h5A at the first m_start and 8'hA5 at the second; exactly 2 m_start pulses; frame_done once; cs_n high afterwards.
- m_ready held 0 for 20 cycles in L_START -> m_start stays 0 and cs_n stays low; m_start fires on the cycle after m_ready rises; no byte is lost.
- send three times during a frame with data_in changing 1111 -> 2222 -> 3333 -> pending=1; a second frame starts after FIN plus IDLE and transmits data_in as sampled at launch (3333 if held); exactly 2 frames in total.
- auto_en=1 with AUTO_PERIOD=50 and short bytes -> frames start every 50 cycles; send coinciding with a tick yields 1 frame, not 2; auto_en=0 stops further frames after the current one.
- rst asserted while in H_WAIT -> cs_n=1 in the same cycle (asynchronous); no frame_done; after release a send gives a clean full frame.
- Parameter sweep BYTE_GAP=0 and CS_SETUP=1 -> H_START follows the low-byte done directly; the first m_start comes 2 cycles after send; cycle counts match the Behaviour rules exactly.
